alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Multi-cycle controller that accepts one command at a time over a valid/ready handshake.
- Drives every control input of the ALU + register-bank datapath through read, execute and write-back phases: read strobes, addresses, alu_op, write strobe, W select and external write data.
- Sits between the instruction decode stage and the ALU/register-bank wrapper.
- Provides a done pulse, an error flag and a captured copy of the ALU result.

Parameters:
ADDR_WIDTH, 4, register address width
WIDTH, 32, datapath width
ALU_LAT, 2, number of EXEC cycles the ALU operands and alu_op are held before R is sampled (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_kind  input  2  00 reg-reg ALU with writeback; 01 load immediate; 10 compare (no writeback); 11 reserved
cmd_alu_op  input  4  ALU opcode
cmd_rs1  input  ADDR_WIDTH  source register 1
cmd_rs2  input  ADDR_WIDTH  source register 2
cmd_rd  input  ADDR_WIDTH  destination register
cmd_imm  input  WIDTH  immediate for load immediate
R  input  WIDTH  ALU result from the datapath
alu_op  output  4  to datapath
read_port_1  output  1  register read enable, port 1
read_port_2  output  1  register read enable, port 2
write_port  output  1  register write enable
W  output  1  1 = write external_write; 0 = write R
addr_port_1  output  ADDR_WIDTH  read address, port 1
addr_port_2  output  ADDR_WIDTH  read address, port 2
addr_port_write  output  ADDR_WIDTH  write address
external_write  output  WIDTH  immediate write data
result  output  WIDTH  R captured at the end of EXEC
done  output  1  one-cycle completion pulse
err  output  1  valid with done; 1 = reserved kind
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including result, addresses and alu_op.
  - Reset mid-command aborts it immediately: write_port drops, no done is issued, the command is lost.
- cmd_ready = (state==IDLE) and rst_n. A handshake occurs on a rising edge with cmd_valid & cmd_ready.
  - On handshake, all cmd_* fields are latched. Later changes on the cmd_* inputs have no effect.
- States: IDLE, READ, EXEC, WRITE, DONE.
- IDLE transitions on handshake:
  - kind 00 or 10 -> READ
  - kind 01 -> WRITE
  - kind 11 -> DONE with err=1
- READ (1 cycle): read_port_1 = read_port_2 = 1; addr_port_1 = rs1; addr_port_2 = rs2; alu_op = latched op.
- EXEC (ALU_LAT cycles, down-counter): read strobes 0; addresses and alu_op held.
  - On the last EXEC edge, result <= R.
  - Then kind 00 -> WRITE; kind 10 -> DONE.
- WRITE (1 cycle): write_port = 1; addr_port_write = rd.
  - kind 00: W = 0 (R written).
  - kind 01: W = 1; external_write = imm.
  - For kind 01, result <= imm on this edge.
- DONE (1 cycle): done = 1; err = 1 only for kind 11. Next state IDLE.
  - cmd_ready returns the cycle after DONE, so back-to-back commands are spaced by at least one IDLE cycle.
- Outside their active state:
  - read_port_*, write_port, W, done and err are 0.
  - Addresses, alu_op, external_write and result hold their last values.
- Latency, counted in cycles after the handshake edge (cycle 1 = first cycle after that edge):
  - kind 00: done in cycle 3+ALU_LAT
  - kind 10: done in cycle 2+ALU_LAT
  - kind 01: done in cycle 2
  - kind 11: done in cycle 1
- rd equal to rs1 or rs2 needs no special handling: reads complete before the write.
- cmd_valid while busy is ignored, and is not latched.

Test Plan:
- Reset, then kind 01, rd=3, imm=0x0000_00A5 -> cycle 1: write_port=1, W=1, addr_port_write=3, external_write=0xA5; cycle 2: done=1, err=0, result=0xA5.
- Preload r1=7, r2=5 (kind 01); kind 00 add, rs1=1, rs2=2, rd=4, ALU_LAT=2 -> cycle 1: read_port_1=read_port_2=1; cycles 2-3: EXEC; cycle 4: write_port=1, W=0; cycle 5: done=1, result=12.
- kind 10 subtract, r1=7, r2=7 -> write_port stays 0 for the whole command; done in cycle 4; result=0.
- kind 11 -> done=1, err=1 in cycle 1; no strobe ever asserted.
- cmd_valid held high with 3 queued commands -> each accepted only when cmd_ready=1; busy=1 throughout each command; cmd_* changes while busy have no effect.
- rst_n pulled low during WRITE of a kind 00 command -> write_port=0 at once; no done; after release cmd_ready=1 and result=0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : alu_op_sequencer
// Brief   : Sequences read, execute and write-back control for the ALU/register bank.
// Revision: 1.0  initial release
// ============================================================================
module alu_op_sequencer #(
   parameter int ADDR_WIDTH = 4,
   parameter int WIDTH      = 32,
   parameter int ALU_LAT    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_kind,
   input  logic [3:0]            cmd_alu_op,
   input  logic [ADDR_WIDTH-1:0] cmd_rs1,
   input  logic [ADDR_WIDTH-1:0] cmd_rs2,
   input  logic [ADDR_WIDTH-1:0] cmd_rd,
   input  logic [WIDTH-1:0]      cmd_imm,
   input  logic [WIDTH-1:0]      R,
   output logic [3:0]            alu_op,
   output logic                  read_port_1,
   output logic                  read_port_2,
   output logic                  write_port,
   output logic                  W,
   output logic [ADDR_WIDTH-1:0] addr_port_1,
   output logic [ADDR_WIDTH-1:0] addr_port_2,
   output logic [ADDR_WIDTH-1:0] addr_port_write,
   output logic [WIDTH-1:0]      external_write,
   output logic [WIDTH-1:0]      result,
   output logic                  done,
   output logic                  err,
   output logic                  busy
);

   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_READ  = 3'd1;
   localparam logic [2:0] c_EXEC  = 3'd2;
   localparam logic [2:0] c_WRITE = 3'd3;
   localparam logic [2:0] c_DONE  = 3'd4;

   localparam logic [1:0] c_KIND_ALU = 2'd0;
   localparam logic [1:0] c_KIND_LI  = 2'd1;
   localparam logic [1:0] c_KIND_CMP = 2'd2;

   localparam logic [3:0] c_LAT_LAST = 4'(ALU_LAT - 1);

   logic [2:0]            r_state;
   logic [1:0]            r_kind;
   logic [ADDR_WIDTH-1:0] r_rd;
   logic [WIDTH-1:0]      r_imm;
   logic [3:0]            r_cnt;
   logic                  w_accept;

   assign cmd_ready   = (r_state == c_IDLE) & rst_n;
   assign w_accept    = cmd_valid & cmd_ready;
   assign busy        = (r_state != c_IDLE);
   assign read_port_1 = (r_state == c_READ);
   assign read_port_2 = (r_state == c_READ);
   assign write_port  = (r_state == c_WRITE);
   assign W           = (r_state == c_WRITE) & (r_kind == c_KIND_LI);
   assign done        = (r_state == c_DONE);
   assign err         = (r_state == c_DONE) & (r_kind == 2'd3);

   // Datapath-facing registers only update on entry to the phase that uses them,
   // so they hold their previous values through unrelated commands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= c_IDLE;
         r_kind          <= 2'd0;
         r_rd            <= '0;
         r_imm           <= '0;
         r_cnt           <= 4'd0;
         alu_op          <= 4'd0;
         addr_port_1     <= '0;
         addr_port_2     <= '0;
         addr_port_write <= '0;
         external_write  <= '0;
         result          <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_accept) begin
                  r_kind <= cmd_kind;
                  r_rd   <= cmd_rd;
                  r_imm  <= cmd_imm;
                  case (cmd_kind)
                     c_KIND_ALU, c_KIND_CMP: begin
                        r_state     <= c_READ;
                        addr_port_1 <= cmd_rs1;
                        addr_port_2 <= cmd_rs2;
                        alu_op      <= cmd_alu_op;
                     end
                     c_KIND_LI: begin
                        r_state         <= c_WRITE;
                        addr_port_write <= cmd_rd;
                        external_write  <= cmd_imm;
                     end
                     default: r_state <= c_DONE;
                  endcase
               end
            end
            c_READ: begin
               r_state <= c_EXEC;
               r_cnt   <= c_LAT_LAST;
            end
            c_EXEC: begin
               if (r_cnt == 4'd0) begin
                  result <= R;
                  if (r_kind == c_KIND_ALU) begin
                     r_state         <= c_WRITE;
                     addr_port_write <= r_rd;
                  end else begin
                     r_state <= c_DONE;
                  end
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            c_WRITE: begin
               if (r_kind == c_KIND_LI) result <= r_imm;
               r_state <= c_DONE;
            end
            c_DONE:  r_state <= c_IDLE;
            default: r_state <= c_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_op_sequencer
// Brief   : Self-checking bench with a register-bank/ALU environment and command-level model.
// Revision: 1.0  initial release
// ============================================================================
module tb_alu_op_sequencer;
   localparam int AW  = 4;
   localparam int DW  = 32;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid, cmd_ready;
   logic [1:0]    cmd_kind;
   logic [3:0]    cmd_alu_op;
   logic [AW-1:0] cmd_rs1, cmd_rs2, cmd_rd;
   logic [DW-1:0] cmd_imm, R;
   logic [3:0]    alu_op;
   logic          read_port_1, read_port_2, write_port, W;
   logic [AW-1:0] addr_port_1, addr_port_2, addr_port_write;
   logic [DW-1:0] external_write, result;
   logic          done, err, busy;

   always #5 clk = ~clk;

   alu_op_sequencer #(.ADDR_WIDTH(AW), .WIDTH(DW), .ALU_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_kind(cmd_kind), .cmd_alu_op(cmd_alu_op), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
      .cmd_rd(cmd_rd), .cmd_imm(cmd_imm), .R(R), .alu_op(alu_op),
      .read_port_1(read_port_1), .read_port_2(read_port_2), .write_port(write_port), .W(W),
      .addr_port_1(addr_port_1), .addr_port_2(addr_port_2), .addr_port_write(addr_port_write),
      .external_write(external_write), .result(result), .done(done), .err(err), .busy(busy)
   );

   function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [3:0] op);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return a << b[4:0];
         default: return a;
      endcase
   endfunction

   // Register bank and ALU environment driven by the sequencer's control outputs
   logic [DW-1:0] dp_regs [16];
   logic          dp_clr;
   always_comb R = alu_f(dp_regs[addr_port_1], dp_regs[addr_port_2], alu_op);
   always_ff @(posedge clk) begin
      if (dp_clr) begin
         for (int i = 0; i < 16; i++) dp_regs[i] <= '0;
      end else if (write_port) begin
         dp_regs[addr_port_write] <= W ? external_write : R;
      end
   end

   logic [DW-1:0] ref_regs [16];
   logic [DW-1:0] ref_result;
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic scramble_cmd();
      cmd_kind   = 2'($urandom);
      cmd_alu_op = 4'($urandom);
      cmd_rs1    = 4'($urandom);
      cmd_rs2    = 4'($urandom);
      cmd_rd     = 4'($urandom);
      cmd_imm    = $urandom;
   endtask

   // Called just after a falling edge; returns at the falling edge inside the done cycle.
   task automatic run_cmd(input logic [1:0] k, input logic [3:0] op, input logic [3:0] rs1,
                          input logic [3:0] rs2, input logic [3:0] rd, input logic [DW-1:0] imm,
                          input bit keep, output int lat, output logic [DW-1:0] res);
      int cyc, wait_n, bad_seq, bad_fld, exp_lat;
      logic exp_rd, exp_wr, err_seen;
      logic [DW-1:0] exp_res;
      exp_res = (k == 2'd0 || k == 2'd2) ? alu_f(ref_regs[rs1], ref_regs[rs2], op)
              : (k == 2'd1) ? imm : ref_result;
      exp_lat = (k == 2'd0) ? LAT + 3 : (k == 2'd2) ? LAT + 2 : (k == 2'd1) ? 2 : 1;
      cmd_valid = 1'b1; cmd_kind = k; cmd_alu_op = op;
      cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd; cmd_imm = imm;
      wait_n = 0;
      while (cmd_ready !== 1'b1 && wait_n < 50) begin
         @(negedge clk);
         wait_n++;
      end
      check("accept_wait", 32'(wait_n < 50), 32'd1);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = keep;
      scramble_cmd();
      cyc = 1; bad_seq = 0; bad_fld = 0; err_seen = 1'b0;
      while (cyc <= 40) begin
         exp_rd = (k == 2'd0 || k == 2'd2) && cyc == 1;
         exp_wr = (k == 2'd0 && cyc == LAT + 2) || (k == 2'd1 && cyc == 1);
         if (read_port_1 !== exp_rd || read_port_2 !== exp_rd || write_port !== exp_wr ||
             W !== (exp_wr && k == 2'd1) || busy !== 1'b1 || cmd_ready !== 1'b0)
            bad_seq++;
         if ((k == 2'd0 || k == 2'd2) && cyc <= LAT + 1 &&
             (addr_port_1 !== rs1 || addr_port_2 !== rs2 || alu_op !== op))
            bad_fld++;
         if (exp_wr && (addr_port_write !== rd || (k == 2'd1 && external_write !== imm)))
            bad_fld++;
         if (done === 1'b1) begin
            err_seen = err;
            break;
         end
         if (err !== 1'b0) bad_seq++;
         @(negedge clk);
         cyc++;
         scramble_cmd();
      end
      check("latency", 32'(cyc), 32'(exp_lat));
      check("err", 32'(err_seen), 32'(k == 2'd3));
      check("strobe_seq", 32'(bad_seq), 32'd0);
      check("ctrl_fields", 32'(bad_fld), 32'd0);
      check("result", result, exp_res);
      if (k == 2'd0 || k == 2'd1) ref_regs[rd] = exp_res;
      ref_result = exp_res;
      check("regfile", dp_regs[rd], ref_regs[rd]);
      if (!keep) cmd_valid = 1'b0;
      lat = cyc;
      res = result;
   endtask

   typedef struct {
      logic [1:0]    kind;
      logic [3:0]    op, rs1, rs2, rd;
      logic [DW-1:0] imm, exp_res;
      int            exp_lat;
      logic          keep;
   } vec_t;

   vec_t vecs [10];

   initial begin
      int lat;
      logic [DW-1:0] res;
      logic [1:0] rk;

      rst_n = 1'b0; dp_clr = 1'b1; cmd_valid = 1'b0;
      cmd_kind = '0; cmd_alu_op = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0; cmd_imm = '0;
      for (int i = 0; i < 16; i++) ref_regs[i] = '0;
      ref_result = '0;

      vecs[0] = '{2'd1, 4'd0, 4'd0, 4'd0, 4'd3, 32'h0000_00A5, 32'h0000_00A5, 2, 1'b0};
      vecs[1] = '{2'd1, 4'd0, 4'd0, 4'd0, 4'd1, 32'd7,         32'd7,         2, 1'b0};
      vecs[2] = '{2'd1, 4'd0, 4'd0, 4'd0, 4'd2, 32'd5,         32'd5,         2, 1'b0};
      vecs[3] = '{2'd0, 4'd0, 4'd1, 4'd2, 4'd4, 32'd0,         32'd12,        5, 1'b0};
      vecs[4] = '{2'd1, 4'd0, 4'd0, 4'd0, 4'd2, 32'd7,         32'd7,         2, 1'b0};
      vecs[5] = '{2'd2, 4'd1, 4'd1, 4'd2, 4'd9, 32'd0,         32'd0,         4, 1'b0};
      vecs[6] = '{2'd3, 4'd0, 4'd0, 4'd0, 4'd0, 32'd0,         32'd0,         1, 1'b0};
      vecs[7] = '{2'd0, 4'd1, 4'd4, 4'd3, 4'd4, 32'd0,         32'hFFFF_FF67, 5, 1'b1};
      vecs[8] = '{2'd0, 4'd0, 4'd4, 4'd4, 4'd4, 32'd0,         32'hFFFF_FECE, 5, 1'b1};
      vecs[9] = '{2'd1, 4'd0, 4'd0, 4'd0, 4'd9, 32'h1234_5678, 32'h1234_5678, 2, 1'b0};

      repeat (2) @(negedge clk);
      check("rst_strobes", 32'({read_port_1, read_port_2, write_port, W, done, err, busy, cmd_ready}), 32'd0);
      check("rst_addr", 32'({alu_op, addr_port_1, addr_port_2, addr_port_write}), 32'd0);
      check("rst_ext", external_write, 32'd0);
      check("rst_result", result, 32'd0);
      dp_clr = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 32'(cmd_ready), 32'd1);

      // Directed table; the last three run back-to-back with cmd_valid held high
      for (int i = 0; i < 10; i++) begin
         run_cmd(vecs[i].kind, vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                 vecs[i].imm, vecs[i].keep, lat, res);
         check("tbl_latency", 32'(lat), 32'(vecs[i].exp_lat));
         check("tbl_result", res, vecs[i].exp_res);
      end
      @(negedge clk);

      for (int n = 0; n < 40; n++) begin
         rk = 2'($urandom_range(0, 3));
         run_cmd(rk, 4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom),
                 $urandom, (n != 39) && ($urandom_range(0, 1) == 1), lat, res);
         if (cmd_valid == 1'b0) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      @(negedge clk);

      // Abort a reg-reg command during its write-back cycle
      cmd_valid = 1'b1; cmd_kind = 2'd0; cmd_alu_op = 4'd0;
      cmd_rs1 = 4'd1; cmd_rs2 = 4'd2; cmd_rd = 4'd5; cmd_imm = '0;
      while (cmd_ready !== 1'b1) @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (LAT + 1) @(negedge clk);
      check("abort_in_write", 32'(write_port), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_wr_drop", 32'(write_port), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_result", result, 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("abort_no_done", 32'(done), 32'd0);
      end
      rst_n = 1'b1;
      ref_result = '0;
      #1;
      check("abort_ready", 32'(cmd_ready), 32'd1);
      check("abort_result_after", result, 32'd0);
      check("abort_no_write", dp_regs[5], ref_regs[5]);
      @(negedge clk);
      run_cmd(2'd1, 4'd0, 4'd0, 4'd0, 4'd6, 32'hCAFE_0001, 1'b0, lat, res);
      check("post_abort_li", res, 32'hCAFE_0001);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
`default_nettype wire
